init_loader: RTL and testbench

INIT_LOADER -- requirements
Module: init_loader

---
 rtl/init_loader.sv | 199 +++++++++++++++++++
 tb/tb_init_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/init_loader.sv
// Streams BTB, BHT, register-file and memory init data into their tables and holds the core in reset until all are loaded.
// Optional feature macro INIT_LOADER_CHECKSUM_EN: mem_chk accumulates a wrapping sum of every memory word written.
module init_loader #(
    parameter int unsigned MEM_WORDS = 64,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic [39:0] btb_init,
    input  logic [7:0]  btb_addr,
    input  logic [1:0]  bht_init,
    input  logic [7:0]  bht_addr,
    input  logic [31:0] reg_init,
    input  logic [4:0]  reg_addr,
    input  logic [31:0] mem_init,
    input  logic [31:0] mem_addr,
    output logic        btb_we,
    output logic [7:0]  btb_waddr,
    output logic [39:0] btb_wdata,
    output logic        bht_we,
    output logic [7:0]  bht_waddr,
    output logic [1:0]  bht_wdata,
    output logic        reg_we,
    output logic [4:0]  reg_waddr,
    output logic [31:0] reg_wdata,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        core_rst,
    output logic        init_done,
    output logic        init_err,
    output logic [31:0] mem_chk
);

    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned MEMC_W = 7;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          btb_exp;
    logic [7:0]          bht_exp;
    logic [4:0]          reg_exp;
    logic [MEMC_W-1:0]   mem_exp;
    logic                btb_fin;
    logic                bht_fin;
    logic                reg_fin;
    logic                mem_fin;
    logic                mem_pend;
    logic [31:0]         mem_pend_addr;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                all_fin;
    logic                acc_btb;
    logic                acc_bht;
    logic                acc_reg;
    logic                acc_mem;
    logic                wr_en;

    // Next state, per-target acceptance and write enable
    always_comb begin
        state_nxt = state;
        all_fin   = btb_fin & bht_fin & reg_fin & mem_fin;
        acc_btb   = 1'b0;
        acc_bht   = 1'b0;
        acc_reg   = 1'b0;
        acc_mem   = 1'b0;
        wr_en     = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_LOAD;
            S_LOAD: begin
                acc_btb = !btb_fin && (btb_addr == btb_exp);
                acc_bht = !bht_fin && (bht_addr == bht_exp);
                acc_reg = !reg_fin && (reg_addr == reg_exp);
                acc_mem = !mem_fin && (mem_addr == 32'(mem_exp));
                if (all_fin && !mem_pend) begin
                    state_nxt = S_DONE;
                end else if (!all_fin && (tmo_cnt == TMO_W'(TIMEOUT - 1))) begin
                    state_nxt = S_ERR;
                end
                // writes launched into a terminal state would violate the quiet-port guarantee
                wr_en = (state_nxt == S_LOAD);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Expected-address counters, done flags and timeout counter
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            btb_exp       <= '0;
            bht_exp       <= '0;
            reg_exp       <= '0;
            mem_exp       <= '0;
            btb_fin       <= 1'b0;
            bht_fin       <= 1'b0;
            reg_fin       <= 1'b0;
            mem_fin       <= 1'b0;
            mem_pend      <= 1'b0;
            mem_pend_addr <= '0;
            tmo_cnt       <= '0;
        end else begin
            if (acc_btb) begin
                btb_exp <= btb_exp + 8'd1;
                btb_fin <= (btb_exp == 8'd255);
            end
            if (acc_bht) begin
                bht_exp <= bht_exp + 8'd1;
                bht_fin <= (bht_exp == 8'd255);
            end
            if (acc_reg) begin
                reg_exp <= reg_exp + 5'd1;
                reg_fin <= (reg_exp == 5'd31);
            end
            if (acc_mem) begin
                mem_exp       <= mem_exp + MEMC_W'(1);
                mem_fin       <= (mem_exp == MEMC_W'(MEM_WORDS - 1));
                mem_pend_addr <= mem_addr;
            end
            mem_pend <= acc_mem && wr_en;
            if (state == S_LOAD) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

    // Registered write ports; memory data trails its address by one cycle
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            btb_we    <= 1'b0;
            btb_waddr <= '0;
            btb_wdata <= '0;
            bht_we    <= 1'b0;
            bht_waddr <= '0;
            bht_wdata <= '0;
            reg_we    <= 1'b0;
            reg_waddr <= '0;
            reg_wdata <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            btb_we <= acc_btb && wr_en;
            bht_we <= acc_bht && wr_en;
            reg_we <= acc_reg && wr_en;
            mem_we <= mem_pend && wr_en;
            if (acc_btb && wr_en) begin
                btb_waddr <= btb_addr;
                btb_wdata <= btb_init;
            end
            if (acc_bht && wr_en) begin
                bht_waddr <= bht_addr;
                bht_wdata <= bht_init;
            end
            if (acc_reg && wr_en) begin
                reg_waddr <= reg_addr;
                reg_wdata <= reg_init;
            end
            if (mem_pend && wr_en) begin
                mem_waddr <= mem_pend_addr;
                mem_wdata <= mem_init;
            end
        end
    end

    // Status outputs follow the state being entered
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            core_rst  <= 1'b1;
            init_done <= 1'b0;
            init_err  <= 1'b0;
        end else begin
            core_rst  <= (state_nxt != S_DONE);
            init_done <= (state_nxt == S_DONE);
            init_err  <= (state_nxt == S_ERR);
        end
    end

`ifdef INIT_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            mem_chk <= '0;
        end else if (mem_pend && wr_en) begin
            mem_chk <= mem_chk + mem_init;
        end
    end
`else
    assign mem_chk = '0;
`endif

endmodule

// File: tb/tb_init_loader.sv
// Self-checking bench for init_loader: stream-level reference model plus directed scenarios.
module tb_init_loader;

    localparam int MEM_WORDS = 41;
    localparam int TIMEOUT   = 600;
`ifdef INIT_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [39:0] btb_init = '0;
    logic [7:0]  btb_addr = '0;
    logic [1:0]  bht_init = '0;
    logic [7:0]  bht_addr = '0;
    logic [31:0] reg_init = '0;
    logic [4:0]  reg_addr = '0;
    logic [31:0] mem_init = '0;
    logic [31:0] mem_addr = '0;
    logic        btb_we, bht_we, reg_we, mem_we;
    logic [7:0]  btb_waddr, bht_waddr;
    logic [39:0] btb_wdata;
    logic [1:0]  bht_wdata;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata, mem_waddr, mem_wdata, mem_chk;
    logic        core_rst, init_done, init_err;

    int n_chk = 0;
    int n_err = 0;

    init_loader #(.MEM_WORDS(MEM_WORDS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_i(rst_i),
        .btb_init(btb_init), .btb_addr(btb_addr),
        .bht_init(bht_init), .bht_addr(bht_addr),
        .reg_init(reg_init), .reg_addr(reg_addr),
        .mem_init(mem_init), .mem_addr(mem_addr),
        .btb_we(btb_we), .btb_waddr(btb_waddr), .btb_wdata(btb_wdata),
        .bht_we(bht_we), .bht_waddr(bht_waddr), .bht_wdata(bht_wdata),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .core_rst(core_rst), .init_done(init_done), .init_err(init_err),
        .mem_chk(mem_chk)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory image: 4,7,2,4 then six 4s then 5s (41 words sum to 196)
    function automatic logic [31:0] memval(input int i);
        case (i)
            0: return 32'd4;
            1: return 32'd7;
            2: return 32'd2;
            3: return 32'd4;
            default: return (i < 10) ? 32'd4 : 32'd5;
        endcase
    endfunction

    // mode 0: clean counters; 1: bht skips 10 once; 2: bht stuck at 5
    task automatic drive(input int mode, input int j);
        btb_addr = 8'(j);
        btb_init = {8'(j), 32'(j * 3 + 1)};
        case (mode)
            1:       bht_addr = (j < 10) ? 8'(j) : 8'(j + 1);
            2:       bht_addr = 8'd5;
            default: bht_addr = 8'(j);
        endcase
        bht_init = 2'(j ^ (j >> 3));
        reg_addr = 5'(j);
        reg_init = {27'd0, reg_addr};
        mem_addr = 32'(j);
        mem_init = (j >= 1) ? memval(j - 1) : 32'd0;
    endtask

    // Reference model: what each write port and status must show, from the stream rules
    int          m_st = 0;          // 0 idle, 1 load, 2 done, 3 err
    int          want [4] = '{0, 0, 0, 0};
    bit          fin  [4] = '{0, 0, 0, 0};
    int          lc = 0;
    bit          pv = 0;
    logic [31:0] pa = '0;
    logic [31:0] m_sum = '0;
    bit          e_btb_we = 0, e_bht_we = 0, e_reg_we = 0, e_mem_we = 0;
    logic [7:0]  e_btb_a = '0, e_bht_a = '0;
    logic [39:0] e_btb_d = '0;
    logic [1:0]  e_bht_d = '0;
    logic [4:0]  e_reg_a = '0;
    logic [31:0] e_reg_d = '0, e_mem_a = '0, e_mem_d = '0;
    int          lim [4] = '{255, 255, 31, MEM_WORDS - 1};

    initial forever begin
        @(posedge clk or posedge rst_i);
        if (rst_i) begin
            m_st = 0; lc = 0; pv = 0; m_sum = '0;
            for (int k = 0; k < 4; k++) begin want[k] = 0; fin[k] = 0; end
            e_btb_we = 0; e_bht_we = 0; e_reg_we = 0; e_mem_we = 0;
        end else begin
            e_btb_we = 0; e_bht_we = 0; e_reg_we = 0; e_mem_we = 0;
            if (m_st == 0) begin
                m_st = 1;
            end else if (m_st == 1) begin
                bit all_f;
                bit mem_hit;
                all_f = fin[0] && fin[1] && fin[2] && fin[3];
                lc++;
                if (all_f && !pv) begin
                    m_st = 2;
                end else if (!all_f && lc >= TIMEOUT) begin
                    m_st = 3; pv = 0;
                end else begin
                    if (!fin[0] && int'(btb_addr) == want[0]) begin
                        e_btb_we = 1; e_btb_a = btb_addr; e_btb_d = btb_init;
                        fin[0] = (want[0] == lim[0]); want[0]++;
                    end
                    if (!fin[1] && int'(bht_addr) == want[1]) begin
                        e_bht_we = 1; e_bht_a = bht_addr; e_bht_d = bht_init;
                        fin[1] = (want[1] == lim[1]); want[1]++;
                    end
                    if (!fin[2] && int'(reg_addr) == want[2]) begin
                        e_reg_we = 1; e_reg_a = reg_addr; e_reg_d = reg_init;
                        fin[2] = (want[2] == lim[2]); want[2]++;
                    end
                    if (pv) begin
                        e_mem_we = 1; e_mem_a = pa; e_mem_d = mem_init;
                        m_sum = m_sum + mem_init;
                    end
                    mem_hit = !fin[3] && (mem_addr == 32'(want[3]));
                    pv = mem_hit;
                    if (mem_hit) begin
                        pa = mem_addr;
                        fin[3] = (want[3] == lim[3]); want[3]++;
                    end
                end
            end
        end
    end

    // Compare process: every negedge, DUT vs model
    initial forever begin
        @(negedge clk);
        check("btb_we", 64'(btb_we), 64'(e_btb_we));
        if (e_btb_we) check("btb_write", {16'd0, btb_waddr, btb_wdata}, {16'd0, e_btb_a, e_btb_d});
        check("bht_we", 64'(bht_we), 64'(e_bht_we));
        if (e_bht_we) check("bht_write", 64'({bht_waddr, bht_wdata}), 64'({e_bht_a, e_bht_d}));
        check("reg_we", 64'(reg_we), 64'(e_reg_we));
        if (e_reg_we) check("reg_write", 64'({reg_waddr, reg_wdata}), 64'({e_reg_a, e_reg_d}));
        check("mem_we", 64'(mem_we), 64'(e_mem_we));
        if (e_mem_we) check("mem_write", {mem_waddr, mem_wdata}, {e_mem_a, e_mem_d});
        check("status", 64'({core_rst, init_done, init_err}),
              64'({m_st != 2, m_st == 2, m_st == 3}));
        check("mem_chk", 64'(mem_chk), CHK_EN ? 64'(m_sum) : 64'd0);
    end

    // Release reset and stream for max_cyc cycles, gathering observations
    task automatic run(input int mode, input int max_cyc,
                       output int done_n, output int err_n, output int last_mem_n,
                       output int c_btb, output int c_bht, output int c_reg, output int c_mem,
                       output int reg_bad, output int last_reg_a, output int first_btb_a);
        done_n = -1; err_n = -1; last_mem_n = -1; c_btb = 0; c_bht = 0; c_reg = 0; c_mem = 0;
        reg_bad = 0; last_reg_a = -1; first_btb_a = -1;
        @(negedge clk);
        drive(mode, 0);
        rst_i = 1'b0;
        for (int n = 1; n <= max_cyc; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (init_done && done_n < 0) done_n = n;
            if (init_err && err_n < 0) err_n = n;
            if (btb_we) begin
                if (first_btb_a < 0) first_btb_a = int'(btb_waddr);
                c_btb++;
            end
            if (bht_we) c_bht++;
            if (reg_we) begin
                c_reg++;
                last_reg_a = int'(reg_waddr);
                if (reg_wdata != {27'd0, reg_waddr}) reg_bad++;
            end
            if (mem_we) begin
                c_mem++;
                last_mem_n = n;
            end
            drive(mode, n - 1);
        end
    endtask

    int dn, en, lm, cb, ch, cr, cm, rb, lr, fb;

    initial begin
        drive(0, 0);
        repeat (3) @(negedge clk);
        check("rst_we", 64'({btb_we, bht_we, reg_we, mem_we}), 64'd0);
        check("rst_waddr", {11'd0, btb_waddr, bht_waddr, reg_waddr, mem_waddr}, 64'd0);
        check("rst_wdata", {btb_wdata, bht_wdata, 22'd0}, 64'd0);
        check("rst_wdata2", {reg_wdata, mem_wdata}, 64'd0);
        check("rst_status", 64'({core_rst, init_done, init_err}), 64'b100);
        check("rst_mem_chk", 64'(mem_chk), 64'd0);

        // Full load with clean counters
        run(0, 300, dn, en, lm, cb, ch, cr, cm, rb, lr, fb);
        check("main_btb_count", 64'(cb), 64'd256);
        check("main_bht_count", 64'(ch), 64'd256);
        check("main_reg_count", 64'(cr), 64'd32);
        check("main_mem_count", 64'(cm), 64'd41);
        check("main_done_edge", 64'(dn), 64'd258);
        check("main_last_mem_edge", 64'(lm), 64'd43);
        check("main_done_after_mem", 64'(dn > lm), 64'd1);
        check("main_reg_pairs", 64'(rb), 64'd0);
        check("main_last_reg", 64'(lr), 64'd31);
        check("main_no_err", 64'(en < 0), 64'd1);
        check("main_mem_chk", 64'(mem_chk), CHK_EN ? 64'd196 : 64'd0);
        check("main_core_rst", 64'(core_rst), 64'd0);

        // Reset pulsed mid-load
        rst_i = 1'b1;
        run(0, 101, dn, en, lm, cb, ch, cr, cm, rb, lr, fb);
        #2 rst_i = 1'b1;
        #1;
        check("midrst_we", 64'({btb_we, bht_we, reg_we, mem_we}), 64'd0);
        check("midrst_status", 64'({core_rst, init_done, init_err}), 64'b100);
        check("midrst_btb", {16'd0, btb_waddr, btb_wdata}, 64'd0);
        check("midrst_mem", {mem_waddr, mem_wdata}, 64'd0);
        check("midrst_chk", 64'(mem_chk), 64'd0);
        run(0, 300, dn, en, lm, cb, ch, cr, cm, rb, lr, fb);
        check("restart_first_btb", 64'(fb), 64'd0);
        check("restart_btb_count", 64'(cb), 64'd256);
        check("restart_done_edge", 64'(dn), 64'd258);

        // BHT stream skips address 10 once
        rst_i = 1'b1;
        run(1, 560, dn, en, lm, cb, ch, cr, cm, rb, lr, fb);
        check("skip_bht_count", 64'(ch), 64'd256);
        check("skip_done_edge", 64'(dn), 64'd513);
        check("skip_no_err", 64'(en < 0), 64'd1);

        // BHT stuck: timeout
        rst_i = 1'b1;
        run(2, 650, dn, en, lm, cb, ch, cr, cm, rb, lr, fb);
        check("tmo_err_edge", 64'(en), 64'(TIMEOUT + 1));
        check("tmo_never_done", 64'(dn < 0), 64'd1);
        check("tmo_bht_count", 64'(ch), 64'd0);
        check("tmo_status", 64'({core_rst, init_done, init_err}), 64'b101);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
